// File: rtl/uart_rx_core_if.sv
// Consumer-side handshake bundle for uart_rx_core: received byte, valid/ack and sticky error flags.
// UART_RX_PARITY_EN adds the parity_err flag.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       err_clr;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ack, err_clr
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ack, err_clr
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 mid-bit sampling with a fixed divisor and a one-entry byte buffer.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity_err flag.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 217,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           uart_rxd,
    uart_rx_core_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             sync1;
    logic             s;

    // Both stages reset high so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: clears are written before the FSM so that a set in the same
            // cycle, being the later non-blocking assignment, takes precedence.
            if (bus.err_clr) begin
                bus.frame_err <= 1'b0;
                bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                bus.parity_err <= 1'b0;
`endif
            end
            if (bus.rx_ack && bus.rx_valid)
                bus.rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!s) begin
                        state    <= ST_START;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!s) begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end else begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {s, shift[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_STOP;
                        if ((^shift) ^ s)
                            bus.parity_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (s) begin
                            // Commit overrides any ack arriving in the same cycle.
                            bus.rx_data  <= shift;
                            bus.rx_valid <= 1'b1;
                            if (bus.rx_valid && !bus.rx_ack)
                                bus.overrun <= 1'b1;
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.frame_err <= 1'b1;
                            state         <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_HIGH: begin
                    if (s) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at CLKS_PER_BIT=16; expected bytes go through a scoreboard queue.
// Build with UART_RX_PARITY_EN to exercise the 8E1 variant.
module tb_uart_rx_core;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYCLES = NBITS * CPB;
    localparam int COMMIT_K     = FRAME_CYCLES - 5;

    logic clk;
    logic reset;
    logic uart_rxd;

    uart_rx_core_if bus ();

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    logic       v_pre, v_post, valid_seen, busy_seen;
    logic [7:0] snap_data;
    logic       snap_valid, snap_ferr, snap_ovr, snap_busy;

    // Drives one frame starting at the next falling edge; k counts falling edges from the start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                              input int ack_at, input int rst_at, input bit expect_commit);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, par_bit, data, 1'b0};
`else
        bits = {par_bit, stop_bit, data, 1'b0};
`endif
        if (expect_commit) exp_q.push_back(data);
        valid_seen = 1'b0;
        for (int k = 0; k < FRAME_CYCLES; k++) begin
            @(negedge clk);
            if (bus.rx_valid) valid_seen = 1'b1;
            if (k == COMMIT_K - 2) v_pre = bus.rx_valid;
            if (k == COMMIT_K + 2) v_post = bus.rx_valid;
            if (rst_at >= 0 && k == rst_at + 4) begin
                snap_data  = bus.rx_data;
                snap_valid = bus.rx_valid;
                snap_ferr  = bus.frame_err;
                snap_ovr   = bus.overrun;
                snap_busy  = bus.busy;
            end
            uart_rxd   = bits[k / CPB];
            bus.rx_ack = (k == ack_at);
            reset      = (rst_at >= 0 && k >= rst_at && k < rst_at + 2);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_byte(input string tag);
        logic [7:0] exp;
        int waited = 0;
        while (bus.rx_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rx_valid: got %b want 1", tag, bus.rx_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got byte %h but nothing expected", tag, bus.rx_data);
        end else begin
            exp = exp_q.pop_front();
            if (bus.rx_data !== exp) begin
                errors++;
                $display("FAIL %s rx_data: got %h want %h", tag, bus.rx_data, exp);
            end
        end
    endtask

    task automatic ack_byte(input string tag);
        idle_cycles(5);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s ack: rx_valid got %b want 0", tag, bus.rx_valid);
        end
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic ferr, input logic ovr);
        checks++;
        if (bus.frame_err !== ferr) begin
            errors++;
            $display("FAIL %s frame_err: got %b want %b", tag, bus.frame_err, ferr);
        end
        checks++;
        if (bus.overrun !== ovr) begin
            errors++;
            $display("FAIL %s overrun: got %b want %b", tag, bus.overrun, ovr);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        uart_rxd    = 1'b1;
        bus.rx_ack  = 1'b0;
        bus.err_clr = 1'b0;
        idle_cycles(3);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset rx_data: got %h want 00", bus.rx_data);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset rx_valid: got %b want 0", bus.rx_valid);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b want 0", bus.busy);
        end
        check_flags("reset", 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        checks++;
        if (bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset parity_err: got %b want 0", bus.parity_err);
        end
`endif
    endtask

    task automatic test_basic();
        logic [7:0] bytes [2] = '{8'h55, 8'hA3};
        foreach (bytes[i]) begin
            send_frame(bytes[i], 1'b1, ^bytes[i], -1, -1, 1'b1);
            checks++;
            if (v_pre !== 1'b0 || v_post !== 1'b1) begin
                errors++;
                $display("FAIL basic latency: valid before/after commit got %b/%b want 0/1", v_pre, v_post);
            end
            expect_byte("basic");
            ack_byte("basic");
            check_flags("basic", 1'b0, 1'b0);
        end
    endtask

    task automatic test_glitch();
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        for (int k = 0; k < 204; k++) begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.rx_valid) valid_seen = 1'b1;
            uart_rxd = (k >= 4);
        end
        checks++;
        if (busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch busy: seen %b now %b want 1/0", busy_seen, bus.busy);
        end
        checks++;
        if (valid_seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch rx_valid: got %b want 0", valid_seen);
        end
        check_flags("glitch", 1'b0, 1'b0);
    endtask

    task automatic test_frame_error();
        logic seen;
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, -1, 1'b0);
        seen = valid_seen;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bus.rx_valid) seen = 1'b1;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_err wait_high busy: got %b want 1", bus.busy);
        end
        check_flags("frame_err bad frame", 1'b1, 1'b0);
        uart_rxd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rx_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err recovery: valid seen %b busy %b want 0/0", seen, bus.busy);
        end
        send_frame(8'h7E, 1'b1, ^8'h7E, -1, -1, 1'b1);
        expect_byte("frame_err next");
        check_flags("frame_err next", 1'b1, 1'b0);
        ack_byte("frame_err next");
        pulse_err_clr();
        check_flags("frame_err clr", 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        logic [7:0] lost;
        send_frame(8'h11, 1'b1, ^8'h11, -1, -1, 1'b1);
        send_frame(8'h22, 1'b1, ^8'h22, -1, -1, 1'b1);
        check_flags("overrun", 1'b0, 1'b1);
        lost = exp_q.pop_front();
        expect_byte("overrun");
        ack_byte("overrun");
        pulse_err_clr();
        check_flags("overrun clr", 1'b0, 1'b0);

        send_frame(8'h11, 1'b1, ^8'h11, -1, -1, 1'b1);
        expect_byte("ack_at_commit first");
        send_frame(8'h22, 1'b1, ^8'h22, COMMIT_K - 1, -1, 1'b1);
        expect_byte("ack_at_commit second");
        check_flags("ack_at_commit", 1'b0, 1'b0);
        idle_cycles(3);
        checks++;
        if (bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_commit hold: rx_valid got %b want 1 (lost %h)", bus.rx_valid, lost);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'hF0, 1'b1, ^8'hF0, -1, 4 * CPB + CPB + 8, 1'b0);
        checks++;
        if (snap_data !== 8'h00 || snap_valid !== 1'b0 || snap_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset outputs: data %h valid %b busy %b want 00/0/0",
                     snap_data, snap_valid, snap_busy);
        end
        checks++;
        if (snap_ferr !== 1'b0 || snap_ovr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset flags: frame_err %b overrun %b want 0/0", snap_ferr, snap_ovr);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset abandoned frame: rx_valid got %b want 0", bus.rx_valid);
        end
        idle_cycles(20);
        send_frame(8'h0F, 1'b1, ^8'h0F, -1, -1, 1'b1);
        expect_byte("mid_reset next");
        check_flags("mid_reset next", 1'b0, 1'b0);
        ack_byte("mid_reset next");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, -1, -1, 1'b1);
        expect_byte("parity good");
        checks++;
        if (bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity good parity_err: got %b want 0", bus.parity_err);
        end
        ack_byte("parity good");
        send_frame(8'h07, 1'b1, 1'b0, -1, -1, 1'b1);
        expect_byte("parity bad");
        checks++;
        if (bus.parity_err !== 1'b1) begin
            errors++;
            $display("FAIL parity bad parity_err: got %b want 1", bus.parity_err);
        end
        ack_byte("parity bad");
        pulse_err_clr();
        checks++;
        if (bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity clr parity_err: got %b want 0", bus.parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
